// File: rtl/hazard_freeze_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_freeze_ctrl
//
// Purpose:
//   Pipeline hazard detection and memory-access freeze control for an in-order
//   pipeline.
//   - A combinational data-hazard detector requests an IF/ID stall and an
//     ID/EX bubble.
//   - A four-state memory FSM (IDLE, REQ, WAIT, ERROR) freezes the whole
//     pipeline while a load/store is outstanding.
//   - A timeout counter makes a memory access that never completes end in a
//     sticky error.
//   - A freeze always takes priority over a hazard stall/bubble.
//
// Optional feature:
//   HAZARD_STALL_COUNTER_EN
//     Defined:   stall_count is a saturating count of cycles in which the
//                pipeline was stalled or frozen.
//     Undefined: stall_count is tied to zero and no counter register exists.
//
// Parameters:
//   MEM_TIMEOUT     Maximum number of WAIT cycles without mem_ready before the
//                   access is declared failed (range 2..255).
//
// Ports:
//   clk             Rising-edge clock for all state.
//   rst             Synchronous, active-high reset.
//   forward_en      Forwarding unit enabled (only load-use hazards stall).
//   id_valid        ID stage holds a valid instruction.
//   src1, src2      ID-stage source register numbers.
//   two_src         src2 is actually read by the ID instruction.
//   exe_wb_en       EXE-stage instruction writes back.
//   exe_mem_r_en    EXE-stage instruction is a load.
//   exe_dst         EXE-stage destination register.
//   mem_wb_en       MEM-stage writeback enable.
//   mem_dst         MEM-stage destination register.
//   mem_access_req  MEM-stage instruction is a load or store.
//   mem_ready       Memory controller completes the access (used in WAIT only).
//   stall_if_id     Hold the PC and the IF/ID register.
//   bubble_id_ex    Load a NOP into ID/EX.
//   freeze_pipe     Hold every pipeline register.
//   mem_start       One-cycle access-start pulse (the REQ cycle).
//   mem_error       Sticky memory-timeout flag.
//   stall_count     Stall statistics (see optional feature above).
// -----------------------------------------------------------------------------
module hazard_freeze_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        forward_en,
  input  logic        id_valid,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic        two_src,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  exe_dst,
  input  logic        mem_wb_en,
  input  logic [3:0]  mem_dst,
  input  logic        mem_access_req,
  input  logic        mem_ready,
  output logic        stall_if_id,
  output logic        bubble_id_ex,
  output logic        freeze_pipe,
  output logic        mem_start,
  output logic        mem_error,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // The counter holds the number of completed WAIT cycles. When the final
  // permitted cycle also lacks mem_ready, the access times out.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] wait_cnt;
  logic       hazard;
  logic       src1_exe_hit;
  logic       src2_exe_hit;
  logic       src1_mem_hit;
  logic       src2_mem_hit;

  // Register-match terms shared by both hazard modes.
  assign src1_exe_hit = (src1 == exe_dst);
  assign src2_exe_hit = two_src & (src2 == exe_dst);
  assign src1_mem_hit = (src1 == mem_dst);
  assign src2_mem_hit = two_src & (src2 == mem_dst);

  // Hazard detection: load-use only when forwarding, full RAW check otherwise.
  always_comb begin
    hazard = 1'b0;
    if (!id_valid) begin
      hazard = 1'b0;
    end else if (forward_en) begin
      hazard = exe_mem_r_en & exe_wb_en & (src1_exe_hit | src2_exe_hit);
    end else begin
      hazard = (exe_wb_en & (src1_exe_hit | src2_exe_hit)) |
               (mem_wb_en & (src1_mem_hit | src2_mem_hit));
    end
  end

  // Memory FSM next state and freeze decode.
  // freeze_pipe is already high in the IDLE cycle that raises a request,
  // so the memory instruction stays in MEM until the access completes.
  always_comb begin
    state_next  = state;
    freeze_pipe = 1'b0;
    case (state)
      IDLE: begin
        if (mem_access_req) begin
          state_next  = REQ;
          freeze_pipe = 1'b1;
        end else begin
          state_next  = IDLE;
          freeze_pipe = 1'b0;
        end
      end
      REQ: begin
        state_next  = WAIT;
        freeze_pipe = 1'b1;
      end
      WAIT: begin
        if (mem_ready) begin
          // Release the pipeline in the completing cycle itself.
          state_next  = IDLE;
          freeze_pipe = 1'b0;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state_next  = ERROR;
          freeze_pipe = 1'b1;
        end else begin
          state_next  = WAIT;
          freeze_pipe = 1'b1;
        end
      end
      ERROR: begin
        state_next  = ERROR;
        freeze_pipe = 1'b1;
      end
      default: begin
        state_next  = IDLE;
        freeze_pipe = 1'b0;
      end
    endcase
  end

  assign mem_start    = (state == REQ);
  assign stall_if_id  = hazard & ~freeze_pipe;
  assign bubble_id_ex = hazard & ~freeze_pipe;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter: WAIT is only ever entered from REQ, so clearing in REQ
  // clears on entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (state == REQ) begin
      wait_cnt <= 8'd0;
    end else if ((state == WAIT) && !mem_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Sticky timeout flag, raised on the edge that enters ERROR.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_error <= 1'b0;
    end else if (state_next == ERROR) begin
      mem_error <= 1'b1;
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [15:0] stall_cnt;

  // Saturating count of stalled or frozen cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
    end else if ((stall_if_id | freeze_pipe) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_freeze_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_freeze_ctrl
//
// Purpose:
//   Directed test of hazard_freeze_ctrl (MEM_TIMEOUT = 4) using a scoreboard.
//   - The stimulus process drives the inputs just after a rising edge.
//   - It then queues the hand-computed expected outputs for that cycle.
//   - A separate monitor samples the outputs on the falling edge and compares
//     them with every expectation queued for the current cycle.
//   - With HAZARD_STALL_COUNTER_EN defined, stall_count is expected to count
//     stalled cycles; otherwise it is expected to stay at zero.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_hazard_freeze_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic        id_valid;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic        exe_wb_en;
  logic        exe_mem_r_en;
  logic [3:0]  exe_dst;
  logic        mem_wb_en;
  logic [3:0]  mem_dst;
  logic        mem_access_req;
  logic        mem_ready;
  logic        stall_if_id;
  logic        bubble_id_ex;
  logic        freeze_pipe;
  logic        mem_start;
  logic        mem_error;
  logic [15:0] stall_count;

  // Expected output bundle per checked cycle.
  // outs = {stall_if_id, bubble_id_ex, freeze_pipe, mem_start, mem_error}
  typedef struct {
    int          cyc;
    string       name;
    logic [4:0]  outs;
    bit          chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  hazard_freeze_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .forward_en     (forward_en),
    .id_valid       (id_valid),
    .src1           (src1),
    .src2           (src2),
    .two_src        (two_src),
    .exe_wb_en      (exe_wb_en),
    .exe_mem_r_en   (exe_mem_r_en),
    .exe_dst        (exe_dst),
    .mem_wb_en      (mem_wb_en),
    .mem_dst        (mem_dst),
    .mem_access_req (mem_access_req),
    .mem_ready      (mem_ready),
    .stall_if_id    (stall_if_id),
    .bubble_id_ex   (bubble_id_ex),
    .freeze_pipe    (freeze_pipe),
    .mem_start      (mem_start),
    .mem_error      (mem_error),
    .stall_count    (stall_count)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected stall_count for the k-th counted cycle in this build.
  function automatic logic [15:0] exp_cnt(input int k);
`ifdef HAZARD_STALL_COUNTER_EN
    return 16'(k);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic expect_now(input string name, input logic [4:0] outs,
                            input bit chk_cnt, input logic [15:0] cnt);
    exp_t e;
    e.cyc     = cyc;
    e.name    = name;
    e.outs    = outs;
    e.chk_cnt = chk_cnt;
    e.cnt     = cnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    forward_en     = 1'b0;
    id_valid       = 1'b0;
    src1           = 4'h0;
    src2           = 4'h0;
    two_src        = 1'b0;
    exe_wb_en      = 1'b0;
    exe_mem_r_en   = 1'b0;
    exe_dst        = 4'h0;
    mem_wb_en      = 1'b0;
    mem_dst        = 4'h0;
    mem_access_req = 1'b0;
    mem_ready      = 1'b0;
  endtask

  task automatic set_load_use();
    forward_en   = 1'b1;
    exe_mem_r_en = 1'b1;
    exe_wb_en    = 1'b1;
    exe_dst      = 4'h3;
    src1         = 4'h3;
    id_valid     = 1'b1;
  endtask

  // Monitor: compare outputs against every expectation due this cycle.
  initial begin
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        act = {stall_if_id, bubble_id_ex, freeze_pipe, mem_start, mem_error};
        checks = checks + 1;
        if (act !== e.outs || (e.chk_cnt && stall_count !== e.cnt)) begin
          errors = errors + 1;
          $display("FAIL %s (cycle %0d): stall,bubble,freeze,start,err=%b expected %b; stall_count=%0d expected %0d (checked=%0d)",
                   e.name, cyc, act, e.outs, stall_count, e.cnt, e.chk_cnt);
        end
      end
    end
  end

  // Watchdog: the sequence is linear, but never allow an endless run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expect_now("reset_state", 5'b00000, 1'b1, 16'h0000);
    tick();

    // Load-use with forwarding.
    set_load_use();
    expect_now("load_use_src1", 5'b11000, 1'b0, 16'h0000);
    tick();
    src1 = 4'h4;
    expect_now("load_use_src1_miss", 5'b00000, 1'b0, 16'h0000);
    tick();
    src1     = 4'h3;
    id_valid = 1'b0;
    expect_now("id_invalid", 5'b00000, 1'b0, 16'h0000);
    tick();
    id_valid = 1'b1;
    src1     = 4'h0;
    src2     = 4'h3;
    two_src  = 1'b1;
    expect_now("load_use_src2", 5'b11000, 1'b0, 16'h0000);
    tick();
    two_src = 1'b0;
    expect_now("load_use_src2_unused", 5'b00000, 1'b0, 16'h0000);
    tick();
    src1         = 4'h3;
    exe_mem_r_en = 1'b0;
    expect_now("fwd_no_load", 5'b00000, 1'b0, 16'h0000);
    tick();

    // No forwarding: any RAW dependency stalls.
    forward_en = 1'b0;
    expect_now("nofwd_exe_raw", 5'b11000, 1'b0, 16'h0000);
    tick();
    clear_inputs();
    id_valid  = 1'b1;
    mem_wb_en = 1'b1;
    mem_dst   = 4'h5;
    src2      = 4'h5;
    two_src   = 1'b1;
    expect_now("nofwd_mem_src2", 5'b11000, 1'b0, 16'h0000);
    tick();
    two_src = 1'b0;
    expect_now("nofwd_mem_src2_unused", 5'b00000, 1'b0, 16'h0000);
    tick();
    src1      = 4'h5;
    mem_wb_en = 1'b0;
    expect_now("nofwd_mem_wb_off", 5'b00000, 1'b0, 16'h0000);
    tick();

    // Memory access: request at cycle 0, ready at cycle 4.
    clear_inputs();
    mem_access_req = 1'b1;
    expect_now("mem_c0_idle_req", 5'b00100, 1'b0, 16'h0000);
    tick();
    mem_access_req = 1'b0;
    expect_now("mem_c1_req", 5'b00110, 1'b0, 16'h0000);
    tick();
    expect_now("mem_c2_wait", 5'b00100, 1'b0, 16'h0000);
    tick();
    expect_now("mem_c3_wait", 5'b00100, 1'b0, 16'h0000);
    tick();
    mem_ready = 1'b1;
    expect_now("mem_c4_ready", 5'b00000, 1'b0, 16'h0000);
    tick();
    expect_now("mem_c5_idle_ready_ignored", 5'b00000, 1'b0, 16'h0000);
    tick();

    // Second access: mem_ready in REQ is ignored; hazard masked while frozen.
    mem_ready      = 1'b0;
    mem_access_req = 1'b1;
    expect_now("mem2_idle_req", 5'b00100, 1'b0, 16'h0000);
    tick();
    mem_access_req = 1'b0;
    mem_ready      = 1'b1;
    expect_now("mem2_req_ready_ignored", 5'b00110, 1'b0, 16'h0000);
    tick();
    mem_ready = 1'b0;
    expect_now("mem2_wait", 5'b00100, 1'b0, 16'h0000);
    tick();
    set_load_use();
    expect_now("hazard_in_wait_masked", 5'b00100, 1'b0, 16'h0000);
    tick();
    mem_ready = 1'b1;
    expect_now("hazard_at_ready", 5'b11000, 1'b0, 16'h0000);
    tick();
    clear_inputs();
    expect_now("mem2_back_idle", 5'b00000, 1'b0, 16'h0000);
    tick();

    // Reset during REQ abandons the access.
    mem_access_req = 1'b1;
    expect_now("rst_req_idle_req", 5'b00100, 1'b0, 16'h0000);
    tick();
    mem_access_req = 1'b0;
    rst            = 1'b1;
    expect_now("rst_req_in_req", 5'b00110, 1'b0, 16'h0000);
    tick();
    rst = 1'b0;
    expect_now("rst_req_abandoned", 5'b00000, 1'b1, 16'h0000);
    tick();
    expect_now("rst_req_no_start", 5'b00000, 1'b0, 16'h0000);
    tick();

    // Timeout with MEM_TIMEOUT = 4.
    mem_access_req = 1'b1;
    expect_now("to_idle_req", 5'b00100, 1'b0, 16'h0000);
    tick();
    mem_access_req = 1'b0;
    expect_now("to_req", 5'b00110, 1'b0, 16'h0000);
    tick();
    for (int w = 1; w <= 4; w++) begin
      expect_now($sformatf("to_wait%0d", w), 5'b00100, 1'b0, 16'h0000);
      tick();
    end
    expect_now("to_error", 5'b00101, 1'b0, 16'h0000);
    tick();
    mem_ready = 1'b1;
    expect_now("to_error_sticky", 5'b00101, 1'b0, 16'h0000);
    tick();
    mem_ready = 1'b0;
    rst       = 1'b1;
    expect_now("to_error_before_rst", 5'b00101, 1'b0, 16'h0000);
    tick();
    rst = 1'b0;
    expect_now("to_after_rst", 5'b00000, 1'b1, 16'h0000);
    tick();

    // Stall counter: 10 hazard stall cycles.
    set_load_use();
    for (int k = 0; k < 10; k++) begin
      expect_now($sformatf("cnt_stall%0d", k), 5'b11000, 1'b1, exp_cnt(k));
      tick();
    end
    clear_inputs();
    expect_now("cnt_after_10", 5'b00000, 1'b1, exp_cnt(10));
    tick();
    expect_now("cnt_hold", 5'b00000, 1'b1, exp_cnt(10));
    tick();
    tick();

    if (sb.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_freeze_ctrl.md
HAZARD_FREEZE_CTRL -- requirements
Module: hazard_freeze_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before a memory error is flagged (range 2..255).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 forward_en  in  1  forwarding unit enabled.
REQ-006 id_valid  in  1  ID stage holds a valid instruction.
REQ-007 src1, src2  in  4 each  ID-stage source register numbers.
REQ-008 two_src  in  1  src2 is actually read by the ID instruction.
REQ-009 exe_wb_en, exe_mem_r_en  in  1 each  EXE-stage instruction writes back / is a load.
REQ-010 exe_dst  in  4  EXE-stage destination register.
REQ-011 mem_wb_en  in  1  MEM-stage writeback enable; mem_dst  in  4  MEM-stage destination register.
REQ-012 mem_access_req  in  1  MEM-stage instruction is a load or store.
REQ-013 mem_ready  in  1  external memory controller completes the access.
REQ-014 stall_if_id  out  1  hold PC and IF/ID register.
REQ-015 bubble_id_ex  out  1  load a NOP into ID/EX.
REQ-016 freeze_pipe  out  1  hold every pipeline register.
REQ-017 mem_start  out  1  one-cycle access-start pulse to the memory controller.
REQ-018 mem_error  out  1  sticky memory-timeout flag.
REQ-019 stall_count  out  16  stall statistics (see Configuration).

Function
REQ-020 The hazard condition SHALL be evaluated combinationally and SHALL be 0 when id_valid=0.
REQ-021 With forward_en=0: hazard = (src1 matches exe_dst with exe_wb_en=1) or (src1 matches mem_dst with mem_wb_en=1), or the same two checks on src2 when two_src=1.
REQ-022 With forward_en=1: hazard = exe_mem_r_en & exe_wb_en & (src1==exe_dst | (two_src & src2==exe_dst)), i.e. load-use only.
REQ-023 The FSM states SHALL be IDLE, REQ, WAIT and ERROR.
- IDLE -> REQ when mem_access_req=1.
- REQ -> WAIT unconditionally.
- WAIT -> IDLE on mem_ready=1.
- WAIT -> ERROR when the wait counter reaches MEM_TIMEOUT without mem_ready.
- ERROR holds until rst.
REQ-024 freeze_pipe SHALL be 1 when any of the following holds: IDLE with mem_access_req=1; state REQ; state WAIT with mem_ready=0; state ERROR.
REQ-025 mem_start SHALL be a Moore output, 1 exactly during the REQ cycle; minimum access latency is therefore 3 cycles from request to release.
REQ-026 mem_ready SHALL be ignored outside WAIT.
REQ-027 In the WAIT cycle where mem_ready=1, freeze_pipe SHALL be 0 so the pipeline advances at that edge; the FSM returns to IDLE, and a new request is taken no earlier than the next cycle.
REQ-028 The 8-bit wait counter SHALL clear on entry to WAIT and increment in each WAIT cycle with mem_ready=0.
REQ-029 stall_if_id = bubble_id_ex = hazard & ~freeze_pipe; a freeze SHALL take priority and no bubble SHALL be inserted while frozen.
REQ-030 mem_error SHALL set on entry to ERROR and remain 1 until rst.

Reset
REQ-031 On rst=1 at a clock edge:
- state SHALL become IDLE;
- the wait counter, mem_error and stall_count SHALL clear to 0;
- registered outputs SHALL read 0 from the following cycle.
REQ-032 Reset during REQ or WAIT SHALL abandon the access; no mem_start SHALL be issued until mem_access_req is sampled again in IDLE.

Configuration
REQ-033 With macro HAZARD_STALL_COUNTER_EN defined, stall_count SHALL increment each cycle where stall_if_id | freeze_pipe is 1 and SHALL saturate at 16'hFFFF.
REQ-034 Without HAZARD_STALL_COUNTER_EN, stall_count SHALL be tied to 16'h0000 and no counter register SHALL be synthesized.

Verification
REQ-035 Load-use case: forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dst=4'h3, src1=4'h3, id_valid=1 -> stall_if_id=1 and bubble_id_ex=1 in the same cycle; changing src1 to 4'h4 -> both 0.
REQ-036 No-forwarding case: forward_en=0, mem_wb_en=1, mem_dst=4'h5, src2=4'h5, two_src=1 -> stall_if_id=1; the same stimulus with two_src=0 -> 0.
REQ-037 Memory access: mem_access_req=1 at cycle 0, mem_ready=1 at cycle 4 -> freeze_pipe=1 on cycles 0..3 and 0 on cycle 4; mem_start=1 only on cycle 1; state IDLE at cycle 5.
REQ-038 Hazard during freeze: a load-use hazard is present while in WAIT -> stall_if_id=0 and bubble_id_ex=0 until the cycle mem_ready=1, then 1.
REQ-039 Timeout: MEM_TIMEOUT=4 and mem_ready held 0 -> ERROR with mem_error=1 after 4 WAIT cycles; freeze_pipe stays 1; rst -> IDLE with mem_error=0.
REQ-040 Counter: with HAZARD_STALL_COUNTER_EN defined, 10 stall cycles -> stall_count=10; with the macro undefined, the same stimulus -> stall_count=0.
